// File: rtl/rolha_scheduler_pkg.sv
// rolha_pkg: shared types and defaults for the cork-dispenser scheduler.
//   state_e   : scheduler FSM state (IDLE, DISP, ADD, GAP)
//   DEF_*     : default parameter values for the scheduler and its interface
//   cnt_width : bits needed by a down-counter that must hold n-1
package rolha_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DISP = 2'd1,
      ADD  = 2'd2,
      GAP  = 2'd3
   } state_e;

   localparam int unsigned DEF_CAP        = 20;
   localparam int unsigned DEF_LOW_TH     = 5;
   localparam int unsigned DEF_INIT_STOCK = 0;
   localparam int unsigned DEF_PULSE_CYC  = 4;
   localparam int unsigned DEF_GAP_CYC    = 2;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rolha_scheduler_if.sv
// rolha_scheduler_if: request/command/status bundle between the bottle line,
// the operator panel and the cork scheduler.
//   req_disp, req_add           : requests (driven by master)
//   disp, add_rolha, ack_disp   : command pulses (driven by slave)
//   stock, rolha5, empty, full,
//   busy                        : status (driven by slave)
// Modports: master = request side, slave = scheduler side.
interface rolha_scheduler_if
   import rolha_pkg::*;
#(
   parameter int unsigned CAP = DEF_CAP
);
   localparam int unsigned SW = $clog2(CAP + 1);

   logic          req_disp;
   logic          req_add;
   logic          disp;
   logic          add_rolha;
   logic          ack_disp;
   logic [SW-1:0] stock;
   logic          rolha5;
   logic          empty;
   logic          full;
   logic          busy;

   modport master (
      output req_disp, req_add,
      input  disp, add_rolha, ack_disp, stock, rolha5, empty, full, busy
   );

   modport slave (
      input  req_disp, req_add,
      output disp, add_rolha, ack_disp, stock, rolha5, empty, full, busy
   );

endinterface

// File: rtl/rolha_scheduler_timer.sv
// rolha_timer: loadable down-counter used for both pulse and gap timing.
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : load load_val_i this cycle (has priority over counting)
//   load_val_i    : value to load
//   value_o       : current count
//   done_o        : count has reached zero (counter then holds at zero)
module rolha_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] value_o,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;
   assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/rolha_scheduler.sv
// rolha_scheduler: sequences the cork dispenser. Arbitrates bottle dispense
// requests against operator refill requests, issues timed disp / add_rolha
// pulses followed by a cooldown gap, and tracks reservoir stock.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : rolha_scheduler_if.slave (requests in, commands/status out)
// Optional feature: define ROLHA_FAIRNESS_EN to force an ADD grant after three
// consecutive DISP grants that were made while a refill was also pending.
module rolha_scheduler
   import rolha_pkg::*;
#(
   parameter int unsigned CAP        = DEF_CAP,
   parameter int unsigned LOW_TH     = DEF_LOW_TH,
   parameter int unsigned INIT_STOCK = DEF_INIT_STOCK,
   parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
   parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
   input  logic               clk,
   input  logic               reset,
   rolha_scheduler_if.slave   bus
);

   localparam int unsigned SW = $clog2(CAP + 1);
   localparam int unsigned TW = cnt_width((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);

   state_e        state_q, state_d;
   logic [SW-1:0] stock_q, stock_d;
   logic          disp_q, disp_d;
   logic          add_q, add_d;
   logic          ack_q, ack_d;

   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic [TW-1:0] tmr_value;
   logic          tmr_done;

   logic          empty_w, full_w;
   logic          disp_ok, add_ok;
   logic          grant_disp, grant_add;

`ifdef ROLHA_FAIRNESS_EN
   logic [1:0]    fair_q, fair_d;
`endif

   assign empty_w = (stock_q == '0);
   assign full_w  = (stock_q == SW'(CAP));
   assign disp_ok = bus.req_disp && !empty_w;
   assign add_ok  = bus.req_add && !full_w;

   rolha_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .value_o    (tmr_value),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d    = state_q;
      stock_d    = stock_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      grant_disp = 1'b0;
      grant_add  = 1'b0;

      case (state_q)
         IDLE: begin
`ifdef ROLHA_FAIRNESS_EN
            if (add_ok && (fair_q == 2'd3)) begin
               grant_add = 1'b1;
            end else if (disp_ok) begin
               grant_disp = 1'b1;
            end else if (add_ok) begin
               grant_add = 1'b1;
            end
`else
            if (disp_ok) begin
               grant_disp = 1'b1;
            end else if (add_ok) begin
               grant_add = 1'b1;
            end
`endif
            if (grant_disp) begin
               state_d  = DISP;
               stock_d  = stock_q - 1'b1;
               tmr_load = 1'b1;
               tmr_val  = TW'(PULSE_CYC - 1);
            end else if (grant_add) begin
               state_d  = ADD;
               tmr_load = 1'b1;
               tmr_val  = TW'(PULSE_CYC - 1);
            end
         end
         DISP: begin
            if (tmr_done) begin
               state_d  = GAP;
               tmr_load = 1'b1;
               tmr_val  = TW'(GAP_CYC - 1);
            end
         end
         ADD: begin
            if (tmr_done) begin
               state_d  = GAP;
               stock_d  = stock_q + 1'b1;
               tmr_load = 1'b1;
               tmr_val  = TW'(GAP_CYC - 1);
            end
         end
         GAP: begin
            if (tmr_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      disp_d = (state_d == DISP);
      add_d  = (state_d == ADD);
      // Registered ack: high when the cycle being entered is the last DISP
      // cycle, i.e. the timer will read zero next cycle.
      ack_d  = (state_d == DISP) &&
               (tmr_load ? (tmr_val == '0) : (tmr_value == TW'(1)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         stock_q <= SW'(INIT_STOCK);
         disp_q  <= 1'b0;
         add_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stock_q <= stock_d;
         disp_q  <= disp_d;
         add_q   <= add_d;
         ack_q   <= ack_d;
      end
   end

`ifdef ROLHA_FAIRNESS_EN
   // Cannot pass 3: at 3 with a refill pending, IDLE grants ADD, which clears it.
   always_comb begin
      fair_d = fair_q;
      if (grant_add) begin
         fair_d = '0;
      end else if (grant_disp && add_ok) begin
         fair_d = fair_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fair_q <= '0;
      end else begin
         fair_q <= fair_d;
      end
   end
`endif

   a_stock_range: assert property (@(posedge clk) disable iff (!reset) stock_q <= SW'(CAP));

   assign bus.disp      = disp_q;
   assign bus.add_rolha = add_q;
   assign bus.ack_disp  = ack_q;
   assign bus.stock     = stock_q;
   assign bus.rolha5    = (32'(stock_q) >= LOW_TH);
   assign bus.empty     = empty_w;
   assign bus.full      = full_w;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rolha_scheduler.sv
module tb_rolha_scheduler;

   localparam int unsigned CAP   = 20;
   localparam int unsigned LOWTH = 5;
   localparam int unsigned INIT  = 0;
   localparam int unsigned P     = 4;
   localparam int unsigned G     = 2;
   localparam int unsigned OPLEN = P + G;
   localparam int unsigned SW    = $clog2(CAP + 1);

   logic clk = 1'b0;
   logic reset;

   rolha_scheduler_if #(.CAP(CAP)) bus ();

   rolha_scheduler #(
      .CAP        (CAP),
      .LOW_TH     (LOWTH),
      .INIT_STOCK (INIT),
      .PULSE_CYC  (P),
      .GAP_CYC    (G)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: an operation is a window of OPLEN cycles after a grant;
   // m_pos is the 1-based position inside that window, 0 when idle.
   int m_stock;
   int m_pos;
   bit m_is_add;
   int m_fair;

   bit prev_disp, prev_add, rose_disp, rose_add;
   bit dut_grants[$];

   typedef struct {
      bit rd;
      bit ra;
      bit disp;
      bit add;
      bit ack;
      bit busy;
      bit empty;
      int stock;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_stock   = INIT;
      m_pos     = 0;
      m_is_add  = 1'b0;
      m_fair    = 0;
      prev_disp = 1'b0;
      prev_add  = 1'b0;
   endtask

   task automatic model_step();
      bit add_ok, disp_ok, take_add;
      if (m_pos != 0) begin
         if (m_is_add && m_pos == P) m_stock++;
         m_pos = (m_pos == OPLEN) ? 0 : m_pos + 1;
      end else begin
         add_ok   = bus.req_add && (m_stock < CAP);
         disp_ok  = bus.req_disp && (m_stock > 0);
         take_add = add_ok && !disp_ok;
`ifdef ROLHA_FAIRNESS_EN
         if (add_ok && m_fair >= 3) take_add = 1'b1;
`endif
         if (take_add) begin
            m_is_add = 1'b1;
            m_pos    = 1;
            m_fair   = 0;
         end else if (disp_ok) begin
            m_is_add = 1'b0;
            m_pos    = 1;
            m_stock--;
            if (add_ok) m_fair++;
         end
      end
   endtask

   function automatic logic [11:0] model_pack();
      bit e_disp, e_add, e_ack;
      e_disp = !m_is_add && m_pos >= 1 && m_pos <= P;
      e_add  = m_is_add && m_pos >= 1 && m_pos <= P;
      e_ack  = !m_is_add && m_pos == P;
      return {e_disp, e_add, e_ack, (m_pos != 0), (m_stock >= LOWTH), (m_stock == 0),
              (m_stock == CAP), SW'(m_stock)};
   endfunction

   function automatic logic [11:0] dut_pack();
      return {bus.disp, bus.add_rolha, bus.ack_disp, bus.busy, bus.rolha5, bus.empty,
              bus.full, bus.stock};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      rose_disp = bus.disp && !prev_disp;
      rose_add  = bus.add_rolha && !prev_add;
      prev_disp = bus.disp;
      prev_add  = bus.add_rolha;
      if (rose_disp) dut_grants.push_back(1'b0);
      if (rose_add)  dut_grants.push_back(1'b1);
      check($sformatf("cycle%0d", cyc), 32'(dut_pack()), 32'(model_pack()));
   endtask

   // which: 0 disp rises, 1 add rises, 2 ack high, 3 not busy
   task automatic wait_for(input int which, input int limit, input string nm);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < limit && !hit; k++) begin
         tick();
         case (which)
            0: hit = rose_disp;
            1: hit = rose_add;
            2: hit = bus.ack_disp;
            default: hit = !bus.busy;
         endcase
      end
      check(nm, 32'(hit), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_seq[6];
      int k, last_edge, edges, cnt;

      //            rd ra disp add ack busy empty stock
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0};
      tbl[1]  = '{1, 1, 0, 1, 0, 1, 1, 0};
      tbl[2]  = '{1, 0, 0, 1, 0, 1, 1, 0};
      tbl[3]  = '{1, 0, 0, 1, 0, 1, 1, 0};
      tbl[4]  = '{1, 0, 0, 1, 0, 1, 1, 0};
      tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 1};
      tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 1};
      tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 1};
      tbl[8]  = '{1, 0, 1, 0, 0, 1, 1, 0};
      tbl[9]  = '{0, 0, 1, 0, 0, 1, 1, 0};
      tbl[10] = '{0, 0, 1, 0, 0, 1, 1, 0};
      tbl[11] = '{0, 0, 1, 0, 1, 1, 1, 0};
      tbl[12] = '{0, 0, 0, 0, 0, 1, 1, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 1, 1, 0};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0};

      reset        = 1'b0;
      bus.req_disp = 1'b0;
      bus.req_add  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'(dut_pack()), 32'({4'b0000, 1'b0, 1'b1, 1'b0, SW'(INIT)}));
      reset = 1'b1;

      // Directed table: refill from empty, pending dispense, mid-pulse request drop.
      for (int i = 0; i < 15; i++) begin
         bus.req_disp = tbl[i].rd;
         bus.req_add  = tbl[i].ra;
         tick();
         check($sformatf("tbl%0d", i),
               {bus.disp, bus.add_rolha, bus.ack_disp, bus.busy, bus.empty, 27'(bus.stock)},
               {tbl[i].disp, tbl[i].add, tbl[i].ack, tbl[i].busy, tbl[i].empty, 27'(tbl[i].stock)});
      end

      // Asynchronous reset during the third add_rolha cycle.
      bus.req_add = 1'b1;
      tick();
      bus.req_add = 1'b0;
      tick();
      tick();
      check("add_3rd_cycle", 32'(bus.add_rolha), 32'd1);
      reset = 1'b0;
      #1;
      check("async_reset", {bus.disp, bus.add_rolha, bus.ack_disp, bus.busy, 28'(bus.stock)},
            {4'b0000, 28'(INIT)});
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("idle_after_reset", 32'(bus.busy), 32'd0);

      // Fill to capacity; held refill request must then be ignored.
      bus.req_add = 1'b1;
      k = 0;
      while (!bus.full && k < 200) begin
         tick();
         k++;
      end
      check("reach_full", 32'(bus.stock), 32'(CAP));
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.add_rolha) cnt++;
      end
      check("full_no_add", 32'(cnt), 32'd0);
      bus.req_disp = 1'b1;
      wait_for(0, 20, "disp_when_full");
      check("stock_after_disp", {31'(bus.stock), bus.full}, {31'(CAP - 1), 1'b0});
      wait_for(2, 20, "ack_when_full");
      bus.req_disp = 1'b0;
      wait_for(1, 20, "refill_after_disp");
      wait_for(3, 20, "refill_done");
      check("stock_back_full", 32'(bus.stock), 32'(CAP));
      bus.req_add = 1'b0;

      // Drain to 10, then measure continuous dispense cadence down to empty.
      bus.req_disp = 1'b1;
      k = 0;
      while (bus.stock != 10 && k < 200) begin
         tick();
         k++;
      end
      check("reach_10", 32'(bus.stock), 32'd10);
      bus.req_disp = 1'b0;
      wait_for(3, 20, "idle_at_10");
      bus.req_disp = 1'b1;
      last_edge = -1;
      edges     = 0;
      for (int c = 0; c < 110; c++) begin
         tick();
         if (rose_disp) begin
            if (last_edge >= 0) check("disp_spacing", 32'(c - last_edge), 32'(OPLEN + 1));
            last_edge = c;
            edges++;
         end
      end
      check("disp_count", 32'(edges), 32'd10);
      check("stall_empty", {bus.empty, bus.disp, bus.busy}, {1'b1, 1'b0, 1'b0});
      bus.req_disp = 1'b0;

      // Refill to LOW_TH, then hold both requests and record grant order.
      bus.req_add = 1'b1;
      k = 0;
      while (bus.stock != LOWTH && k < 100) begin
         tick();
         k++;
      end
      bus.req_add = 1'b0;
      check("reach_5", 32'(bus.stock), 32'(LOWTH));
      wait_for(3, 20, "idle_at_5");
      dut_grants.delete();
      bus.req_disp = 1'b1;
      bus.req_add  = 1'b1;
      k = 0;
      while (dut_grants.size() < 6 && k < 100) begin
         tick();
         if (dut_grants.size() == 1 && rose_disp)
            check("first_grant_stock", {30'(bus.stock), bus.rolha5, bus.disp},
                  {30'(LOWTH - 1), 1'b0, 1'b1});
         k++;
      end
`ifdef ROLHA_FAIRNESS_EN
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
      check("grant_count", 32'(dut_grants.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < dut_grants.size())
            check($sformatf("grant%0d_is_add", i), 32'(dut_grants[i]), 32'(exp_seq[i]));
      end
      bus.req_disp = 1'b0;
      bus.req_add  = 1'b0;
      wait_for(3, 20, "idle_after_arb");

      // Randomized traffic with varying request bias.
      for (int blk = 0; blk < 8; blk++) begin
         int pd, pa;
         pd = $urandom_range(10, 90);
         pa = $urandom_range(10, 90);
         for (int i = 0; i < 200; i++) begin
            bus.req_disp = ($urandom_range(0, 99) < pd);
            bus.req_add  = ($urandom_range(0, 99) < pa);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rolha_scheduler.md
# rolha_scheduler

Controller that sits in front of the cork (rolha) dispenser FSM and sequences it. It arbitrates between bottle-line dispense requests and operator refill requests, and generates timed `disp` / `add_rolha` command pulses. It tracks the reservoir stock and derives the `rolha5` threshold flag that the dispenser logic consumes.

## Interface
Parameters:
- `CAP`, 20: reservoir capacity in corks.
- `LOW_TH`, 5: threshold for the `rolha5` flag (stock ≥ LOW_TH).
- `INIT_STOCK`, 0: stock value loaded on reset. Must be ≤ CAP.
- `PULSE_CYC`, 4: cycles each command pulse is held high. Must be ≥ 1.
- `GAP_CYC`, 2: cooldown cycles after each pulse. Must be ≥ 1.

Ports:
- `clk` in 1: single system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_disp` in 1: bottle at capping station, level-held until `ack_disp`.
- `req_add` in 1: operator refill request (switch_add_rolha), level.
- `disp` out 1: dispense command to dispenser.
- `add_rolha` out 1: load-one-cork command.
- `ack_disp` out 1: one-cycle pulse, dispense completed.
- `stock` out $clog2(CAP+1): current cork count.
- `rolha5` out 1: stock ≥ LOW_TH.
- `empty` out 1: stock == 0.
- `full` out 1: stock == CAP.
- `busy` out 1: state ≠ IDLE.

## Operation
- States:
  - IDLE: wait for a request.
  - DISP: drive the dispense pulse.
  - ADD: drive the refill pulse.
  - GAP: cooldown.
- IDLE transitions:
  - `req_disp` && !empty → DISP.
  - else `req_add` && !full → ADD.
  - else stay in IDLE.
- Arbitration: dispense has strict priority when both requests are valid.
- DISP:
  - `disp`=1 for PULSE_CYC cycles.
  - `stock` decrements by 1 on the DISP entry edge.
  - `ack_disp`=1 on the last DISP cycle.
  - Then → GAP.
- ADD:
  - `add_rolha`=1 for PULSE_CYC cycles.
  - `stock` increments by 1 on the ADD→GAP edge (cork physically loaded).
  - Then → GAP.
- GAP: all commands low for GAP_CYC cycles, then → IDLE.
- Requests are sampled only in IDLE. Deasserting a request mid-operation does not abort the operation.
- `req_disp` with empty=1: no grant, request stays pending. It is granted after a refill raises stock.
- `req_add` with full=1: ignored.
- Stock never wraps below 0 or above CAP. The guards above guarantee this; an assertion checks it.
- `rolha5`, `empty`, `full` and `busy` are combinational from registered stock/state.
- Reset, at any time including mid-pulse: state=IDLE, stock=INIT_STOCK, and `disp`, `add_rolha`, `ack_disp` and the timer go to 0 immediately.

## Timing
- Grant latency: a request seen at rising edge t raises the command from edge t, i.e. during cycle t+1.
- One operation occupies PULSE_CYC+GAP_CYC cycles. Back-to-back grants are therefore spaced PULSE_CYC+GAP_CYC+1 cycles apart (one IDLE cycle).
- Reset values: `disp`=0, `add_rolha`=0, `ack_disp`=0, `busy`=0, `stock`=INIT_STOCK, flags derived from INIT_STOCK.
- Commands are registered outputs, glitch-free.

## Configuration
- `ROLHA_FAIRNESS_EN` defined:
  - A 2-bit counter tracks consecutive DISP grants made while `req_add` && !full was also pending.
  - After 3 such grants, the next IDLE decision grants ADD.
  - The counter clears on any ADD grant and on reset.
- `ROLHA_FAIRNESS_EN` undefined: strict dispense priority; no counter is synthesized.

## Structure
- Package `rolha_pkg`: state enum (IDLE, DISP, ADD, GAP, 2-bit) and default constants (CAP, LOW_TH, PULSE_CYC, GAP_CYC).
- Sub-module `rolha_timer`: loadable down-counter with `load`, `value` and a `done` flag. It times both PULSE and GAP.
- FSM, stock counter and arbitration stay in the top module.

## Test plan
- Reset with INIT_STOCK=0, then `req_disp`=1 → no `disp`, empty=1. Pulse `req_add` 1 cycle → `add_rolha` high 4 cycles, stock=1 after the pulse. After GAP, DISP is granted, stock=0, `ack_disp` pulses once.
- INIT_STOCK=20, `req_add` held → no `add_rolha` ever, full=1. `req_disp` → stock 19, full=0. Then ADD is granted, stock returns to 20.
- INIT_STOCK=5, both requests held → DISP first (stock 4, rolha5 drops to 0). Without the macro, DISP repeats until empty, then ADD. With `ROLHA_FAIRNESS_EN`, the 4th grant is ADD.
- Drop `req_disp` on the 2nd pulse cycle → `disp` still high for 4 cycles, `ack_disp` issued, stock decremented once.
- Assert `reset` low on the 3rd cycle of `add_rolha` → outputs 0 in the same cycle, stock=INIT_STOCK. After release, FSM is in IDLE.
- Continuous `req_disp` from stock 10 → `disp` rising edges exactly 7 cycles apart, 10 dispenses, then stall with empty=1.
